// File: rtl/mmio_arbiter_2x1.sv
// Two-master, single-slave uncached MMIO arbiter with round-robin priority.
// It keeps one transaction in flight and returns each response to the master that issued it.
module mmio_arbiter_2x1 #(
  parameter int FIRST_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,

  output logic        in0_req_ready,
  input  logic        in0_req_valid,
  input  logic [31:0] in0_req_bits_addr,
  input  logic [31:0] in0_req_bits_data,
  input  logic        in0_req_bits_func,
  input  logic [3:0]  in0_req_bits_wstrb,
  input  logic        in0_resp_ready,
  output logic        in0_resp_valid,
  output logic [31:0] in0_resp_bits_data,

  output logic        in1_req_ready,
  input  logic        in1_req_valid,
  input  logic [31:0] in1_req_bits_addr,
  input  logic [31:0] in1_req_bits_data,
  input  logic        in1_req_bits_func,
  input  logic [3:0]  in1_req_bits_wstrb,
  input  logic        in1_resp_ready,
  output logic        in1_resp_valid,
  output logic [31:0] in1_resp_bits_data,

  input  logic        out_req_ready,
  output logic        out_req_valid,
  output logic [31:0] out_req_bits_addr,
  output logic [31:0] out_req_bits_data,
  output logic        out_req_bits_func,
  output logic [3:0]  out_req_bits_wstrb,
  output logic        out_resp_ready,
  input  logic        out_resp_valid,
  input  logic [31:0] out_resp_bits_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        func_q, func_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  req_vld;
  logic        grant_vld;
  logic        grant_idx;

  assign req_vld = {in1_req_valid, in0_req_valid};

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = prio_q;
    if (req_vld[prio_q]) begin
      grant_vld = 1'b1;
      grant_idx = prio_q;
    end else if (req_vld[~prio_q]) begin
      grant_vld = 1'b1;
      grant_idx = ~prio_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    func_d         = func_q;
    wstrb_d        = wstrb_q;
    rdata_d        = rdata_q;
    in0_req_ready  = 1'b0;
    in1_req_ready  = 1'b0;
    in0_resp_valid = 1'b0;
    in1_resp_valid = 1'b0;
    out_req_valid  = 1'b0;
    out_resp_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          in0_req_ready = ~grant_idx;
          in1_req_ready = grant_idx;
          owner_d       = grant_idx;
          addr_d        = grant_idx ? in1_req_bits_addr  : in0_req_bits_addr;
          wdata_d       = grant_idx ? in1_req_bits_data  : in0_req_bits_data;
          func_d        = grant_idx ? in1_req_bits_func  : in0_req_bits_func;
          wstrb_d       = grant_idx ? in1_req_bits_wstrb : in0_req_bits_wstrb;
          state_d       = REQ;
        end
      end
      REQ: begin
        out_req_valid = 1'b1;
        if (out_req_ready) state_d = WAIT;
      end
      WAIT: begin
        out_resp_ready = 1'b1;
        if (out_resp_valid) begin
          rdata_d = out_resp_bits_data;
          state_d = RESP;
        end
      end
      RESP: begin
        in0_resp_valid = ~owner_q;
        in1_resp_valid = owner_q;
        if (owner_q ? in1_resp_ready : in0_resp_ready) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so handshake outputs are masked to stay quiet while it is held.
    if (!reset) begin
      in0_req_ready  = 1'b0;
      in1_req_ready  = 1'b0;
      in0_resp_valid = 1'b0;
      in1_resp_valid = 1'b0;
      out_req_valid  = 1'b0;
      out_resp_ready = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'(FIRST_PRIO);
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    func_q  <= func_d;
    wstrb_q <= wstrb_d;
    rdata_q <= rdata_d;
  end

  assign out_req_bits_addr  = addr_q;
  assign out_req_bits_data  = wdata_q;
  assign out_req_bits_func  = func_q;
  assign out_req_bits_wstrb = wstrb_q;
  assign in0_resp_bits_data = rdata_q;
  assign in1_resp_bits_data = rdata_q;

endmodule

// File: tb/tb_mmio_arbiter_2x1.sv
// Randomized and directed bench for mmio_arbiter_2x1, checked every cycle
// against a transaction-level model of the arbiter.
module tb_mmio_arbiter_2x1;

  localparam int FP = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  rv = '0;
  logic [31:0] raddr [2];
  logic [31:0] rdata [2];
  logic        rfunc [2];
  logic [3:0]  rwstrb [2];
  logic [1:0]  rsp_rdy = '0;
  logic [1:0]  req_rdy;
  logic [1:0]  rsp_vld;
  logic [31:0] rsp_data [2];
  logic        o_req_ready = 1'b0;
  logic        o_req_valid;
  logic [31:0] o_addr, o_data;
  logic        o_func;
  logic [3:0]  o_wstrb;
  logic        o_resp_ready;
  logic        o_resp_valid = 1'b0;
  logic [31:0] o_resp_data = '0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  mmio_arbiter_2x1 #(.FIRST_PRIO(FP)) dut (
    .clock(clock), .reset(reset),
    .in0_req_ready(req_rdy[0]), .in0_req_valid(rv[0]),
    .in0_req_bits_addr(raddr[0]), .in0_req_bits_data(rdata[0]),
    .in0_req_bits_func(rfunc[0]), .in0_req_bits_wstrb(rwstrb[0]),
    .in0_resp_ready(rsp_rdy[0]), .in0_resp_valid(rsp_vld[0]), .in0_resp_bits_data(rsp_data[0]),
    .in1_req_ready(req_rdy[1]), .in1_req_valid(rv[1]),
    .in1_req_bits_addr(raddr[1]), .in1_req_bits_data(rdata[1]),
    .in1_req_bits_func(rfunc[1]), .in1_req_bits_wstrb(rwstrb[1]),
    .in1_resp_ready(rsp_rdy[1]), .in1_resp_valid(rsp_vld[1]), .in1_resp_bits_data(rsp_data[1]),
    .out_req_ready(o_req_ready), .out_req_valid(o_req_valid),
    .out_req_bits_addr(o_addr), .out_req_bits_data(o_data),
    .out_req_bits_func(o_func), .out_req_bits_wstrb(o_wstrb),
    .out_resp_ready(o_resp_ready), .out_resp_valid(o_resp_valid), .out_resp_bits_data(o_resp_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: one pending transaction with its progress flags.
  bit          m_busy = 0, m_sent = 0, m_have_rsp = 0;
  int          m_prio = FP;
  int          m_owner = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_func;
  logic [3:0]  m_wstrb;

  function automatic int winner();
    if (rv[m_prio]) return m_prio;
    if (rv[1 - m_prio]) return 1 - m_prio;
    return -1;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_busy = 0; m_sent = 0; m_have_rsp = 0; m_prio = FP;
    end else if (!m_busy) begin
      int w;
      w = winner();
      if (w >= 0) begin
        m_busy = 1; m_owner = w;
        m_addr = raddr[w]; m_wdata = rdata[w]; m_func = rfunc[w]; m_wstrb = rwstrb[w];
      end
    end else if (!m_sent) begin
      if (o_req_ready) m_sent = 1;
    end else if (!m_have_rsp) begin
      if (o_resp_valid) begin m_have_rsp = 1; m_rdata = o_resp_data; end
    end else if (rsp_rdy[m_owner]) begin
      m_busy = 0; m_sent = 0; m_have_rsp = 0; m_prio = 1 - m_owner;
    end
  end

  always begin
    @(negedge clock);
    #1;
    begin
      int w;
      bit r;
      r = reset;
      w = (!m_busy) ? winner() : -1;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("req_ready%0d", m), 32'(req_rdy[m]), 32'(r && w == m));
        chk($sformatf("resp_valid%0d", m), 32'(rsp_vld[m]), 32'(r && m_have_rsp && m_owner == m));
        if (r && m_have_rsp && m_owner == m)
          chk($sformatf("resp_data%0d", m), rsp_data[m], m_rdata);
      end
      chk("out_req_valid", 32'(o_req_valid), 32'(r && m_busy && !m_sent));
      chk("out_resp_ready", 32'(o_resp_ready), 32'(r && m_sent && !m_have_rsp));
      if (r && m_busy && !m_sent) begin
        chk("out_addr", o_addr, m_addr);
        chk("out_data", o_data, m_wdata);
        chk("out_func", 32'(o_func), 32'(m_func));
        chk("out_wstrb", 32'(o_wstrb), 32'(m_wstrb));
      end
    end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      raddr[m] = '0; rdata[m] = '0; rfunc[m] = 1'b0; rwstrb[m] = '0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Single read from master 0, device answers three cycles into WAIT.
    @(negedge clock);
    rv[0] = 1'b1; raddr[0] = 32'h1fd003f8; rfunc[0] = 1'b0; rwstrb[0] = 4'h0;
    #1 chk("rd_grant0", 32'(req_rdy[0]), 32'd1); chk("rd_grant1", 32'(req_rdy[1]), 32'd0);
    @(negedge clock);
    rv[0] = 1'b0; o_req_ready = 1'b1;
    #1 chk("rd_oreq_v", 32'(o_req_valid), 32'd1); chk("rd_addr", o_addr, 32'h1fd003f8);
    chk("rd_func", 32'(o_func), 32'd0);
    @(negedge clock);
    o_req_ready = 1'b0;
    #1 chk("rd_oreq_drop", 32'(o_req_valid), 32'd0); chk("rd_rsp_rdy", 32'(o_resp_ready), 32'd1);
    @(negedge clock);
    @(negedge clock);
    o_resp_valid = 1'b1; o_resp_data = 32'hdeadbeef;
    @(negedge clock);
    o_resp_valid = 1'b0; o_resp_data = 32'h0;
    #1 chk("rd_rsp_v0", 32'(rsp_vld[0]), 32'd1); chk("rd_rsp_d0", rsp_data[0], 32'hdeadbeef);
    chk("rd_rsp_v1", 32'(rsp_vld[1]), 32'd0);
    @(negedge clock);
    rsp_rdy[0] = 1'b1;
    #1 chk("rd_rsp_hold", 32'(rsp_vld[0]), 32'd1);
    @(negedge clock);
    rsp_rdy[0] = 1'b0;
    #1 chk("rd_done", 32'(rsp_vld[0]), 32'd0);

    // Contention from reset: both masters always valid, device always ready, grants alternate.
    @(negedge clock) reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k == 0) begin
        reset = 1'b1; rv = 2'b11; rsp_rdy = 2'b11; o_req_ready = 1'b1; o_resp_valid = 1'b1;
        raddr[0] = 32'h1000; rfunc[0] = 1'b0;
        raddr[1] = 32'h2000; rdata[1] = 32'h12345678; rfunc[1] = 1'b1; rwstrb[1] = 4'h3;
      end
      o_resp_data = 32'hc0de0000 + 32'(k);
      #1;
      chk($sformatf("ct_rdy0_k%0d", k), 32'(req_rdy[0]), 32'(k % 4 == 0 && (k / 4) % 2 == 0));
      chk($sformatf("ct_rdy1_k%0d", k), 32'(req_rdy[1]), 32'(k % 4 == 0 && (k / 4) % 2 == 1));
      if (k == 5) begin
        chk("wr_addr", o_addr, 32'h2000); chk("wr_data", o_data, 32'h12345678);
        chk("wr_func", 32'(o_func), 32'd1); chk("wr_wstrb", 32'(o_wstrb), 32'h3);
      end
      if (k == 7) begin
        chk("wr_rsp_v1", 32'(rsp_vld[1]), 32'd1); chk("wr_rsp_v0", 32'(rsp_vld[0]), 32'd0);
        chk("wr_rsp_d1", rsp_data[1], 32'hc0de0006);
      end
    end

    // Reset while waiting for the device; the late response must be discarded.
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    reset = 1'b1; rv = 2'b01; rsp_rdy = 2'b00; o_resp_valid = 1'b0; o_req_ready = 1'b1;
    raddr[0] = 32'h100;
    @(negedge clock) rv = 2'b00;
    @(negedge clock);
    #1 chk("rw_wait", 32'(o_resp_ready), 32'd1);
    @(negedge clock) reset = 1'b0;
    #1 chk("rw_in_rst", 32'(o_resp_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1; o_resp_valid = 1'b1; o_resp_data = 32'hbad0bad0;
    #1 chk("rw_late_rr", 32'(o_resp_ready), 32'd0); chk("rw_late_v0", 32'(rsp_vld[0]), 32'd0);
    @(negedge clock) o_resp_valid = 1'b0;
    #1 chk("rw_after_v0", 32'(rsp_vld[0]), 32'd0);
    @(negedge clock);
    rv = 2'b01; raddr[0] = 32'h200;
    #1 chk("rw_regrant", 32'(req_rdy[0]), 32'd1);
    @(negedge clock) rv = 2'b00;
    #1 chk("rw_oreq_v", 32'(o_req_valid), 32'd1); chk("rw_addr", o_addr, 32'h200);

    // Random traffic with backpressure, response stalls and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 299) != 0);
      rv = 2'($urandom);
      for (int m = 0; m < 2; m++) begin
        raddr[m] = $urandom; rdata[m] = $urandom;
        rfunc[m] = 1'($urandom); rwstrb[m] = 4'($urandom);
        rsp_rdy[m] = ($urandom_range(0, 3) != 0);
      end
      o_req_ready = ($urandom_range(0, 2) == 0);
      o_resp_valid = ($urandom_range(0, 2) == 0);
      o_resp_data = $urandom;
    end

    @(negedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
